// File: rtl/req_rsp_responder.sv
// Request/response responder: small register memory with in-order, buffered responses.
// Latency: response visible LATENCY cycles after request accept; one request per cycle sustained.
// Backpressure: req_ready drops at RSP_DEPTH outstanding; rsp_* hold until rsp_ready retires them.

// Generic first-word-fall-through FIFO: head entry is presented while not empty.
// Latency: a push is visible at the output the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push when full, pops when empty are ignored.
module req_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             pop;
    logic             full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop   = pop_i && (cnt_q != '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign vld_o = (cnt_q != '0);
    assign dat_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_dat_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({push_i, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full))
        else $error("push into full response fifo");
endmodule

module req_rsp_responder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 12,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int OW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [OW-1:0]         outst_q, outst_d;
    logic [LATENCY-1:0]    pipe_vld_q;
    rsp_t                  pipe_dat_q [LATENCY];
    rsp_t                  acc_rsp;
    rsp_t                  fifo_dat;
    logic                  fifo_vld;
    logic                  accept, retire, in_range;

    assign req_ready = (outst_q < OW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign retire    = rsp_valid && rsp_ready;
    assign in_range  = ({1'b0, req_addr} < MEM_LIM);

    // Read data is taken from the pre-edge memory, so a same-edge write is not visible.
    always_comb begin
        acc_rsp       = '0;
        acc_rsp.write = req_write;
        acc_rsp.err   = !in_range;
        if (in_range && !req_write) acc_rsp.rdata = mem_q[req_addr];
    end

    always_comb begin
        outst_d = outst_q;
        case ({accept, retire})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            outst_q <= outst_d;
            if (accept && req_write && in_range) mem_q[req_addr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_dat_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_dat_q[0] <= acc_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
        end
    end

    // Outstanding limit bounds pipeline plus FIFO occupancy, so the FIFO cannot overflow.
    req_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (pipe_vld_q[LATENCY-1]),
        .push_dat_i (pipe_dat_q[LATENCY-1]),
        .pop_i      (rsp_ready),
        .vld_o      (fifo_vld),
        .dat_o      (fifo_dat)
    );

    assign rsp_valid = fifo_vld;
    assign rsp_write = fifo_vld & fifo_dat.write;
    assign rsp_err   = fifo_vld & fifo_dat.err;
    assign rsp_rdata = fifo_vld ? fifo_dat.rdata : '0;
endmodule

// File: tb/tb_req_rsp_responder.sv
// Bench for req_rsp_responder: queue-based reference model checked every cycle,
// plus directed literal checks for latency, range errors, backpressure and reset.
module tb_req_rsp_responder;
    localparam int LAT = 2;
    localparam int RD  = 4;
    localparam int MD  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad = 0;

    req_rsp_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of expected responses, each stamped with its accept edge.
    typedef struct {
        bit          w;
        bit          e;
        logic [31:0] d;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mmem [16];
    int          edge_n = 0;
    int          n_acc = 0;
    int          n_ret = 0;

    function automatic bit m_vld();
        return (q.size() > 0) && (q[0].t + LAT <= edge_n);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit   ret, acc;
        exp_t e;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 16; i++) mmem[i] = '0;
        end else begin
            ret = rsp_ready && m_vld();
            acc = req_valid && (q.size() < RD);
            edge_n++;
            if (ret) begin
                void'(q.pop_front());
                n_ret++;
            end
            if (acc) begin
                e.w = req_write;
                e.e = (int'(req_addr) >= MD);
                e.d = (!req_write && !e.e) ? mmem[req_addr] : 32'h0;
                e.t = edge_n;
                q.push_back(e);
                n_acc++;
                if (req_write && !e.e) mmem[req_addr] = req_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", req_ready, (q.size() < RD));
            chk("rsp_valid", rsp_valid, m_vld());
            if (m_vld()) begin
                chk("rsp_write", rsp_write, q[0].w);
                chk("rsp_err", rsp_err, q[0].e);
                chk("rsp_rdata", rsp_rdata, q[0].d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on an idle responder with rsp_ready high; response checked at exact latency.
    task automatic single(input string nm, input bit w, input logic [3:0] a, input logic [31:0] d,
                          input bit ew, input bit ee, input logic [31:0] ed);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        chk({nm, "_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        tick();
        chk({nm, "_early"}, rsp_valid, 0);
        tick();
        chk({nm, "_vld"}, rsp_valid, 1);
        chk({nm, "_write"}, rsp_write, ew);
        chk({nm, "_err"}, rsp_err, ee);
        chk({nm, "_rdata"}, rsp_rdata, ed);
        tick();
    endtask

    task automatic drain(input string nm);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk({nm, "_drained"}, q.size(), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int          sent;
        int          nvld;
        bit          acc_prev;
        logic [3:0]  a;
        logic [31:0] d7;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_write", rsp_write, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: write then read @3 back-to-back, two-cycle latency
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 32'hDEADBEEF;
        tick();
        req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("t1_not_yet", rsp_valid, 0);
        tick();
        chk("t1_wr_vld", rsp_valid, 1);
        chk("t1_wr_write", rsp_write, 1);
        chk("t1_wr_err", rsp_err, 0);
        tick();
        chk("t1_rd_vld", rsp_valid, 1);
        chk("t1_rd_write", rsp_write, 0);
        chk("t1_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("t1_idle", rsp_valid, 0);

        // 2: unwritten word and out-of-range address
        single("t2_rd5", 1'b0, 4'd5, 32'h0, 1'b0, 1'b0, 32'h0);
        single("t2_wr13", 1'b1, 4'd13, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0);
        single("t2_rd13", 1'b0, 4'd13, 32'h0, 1'b0, 1'b1, 32'h0);

        // 3: six back-to-back reads against a stalled response side
        rsp_ready = 1'b0;
        sent = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd0;
        for (int c = 0; c < 6; c++) begin
            if (req_ready) sent++;
            tick();
            req_addr = 4'(sent);
        end
        chk("t3_accepted", sent, 4);
        chk("t3_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && sent < 6; c++) begin
            if (req_ready) sent++;
            tick();
            req_addr = 4'(sent);
            if (sent == 6) req_valid = 1'b0;
        end
        chk("t3_all_sent", sent, 6);
        drain("t3");

        // 4: full, single retire frees one slot, refill makes it full again
        rsp_ready = 1'b0;
        sent = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd1;
        for (int c = 0; c < 8 && sent < 4; c++) begin
            if (req_ready) sent++;
            tick();
        end
        tick();
        tick();
        chk("t4_full", req_ready, 0);
        chk("t4_head", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t4_freed", req_ready, 1);
        tick();
        chk("t4_refull", req_ready, 0);
        tick();
        chk("t4_stays_low", req_ready, 0);
        drain("t4");

        // 5: write @7 then read @7, then random traffic with random rsp_ready
        d7 = $urandom;
        rsp_ready = ($urandom_range(0, 1) != 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd7;
        req_wdata = d7;
        tick();
        rsp_ready = ($urandom_range(0, 1) != 0);
        req_write = 1'b0;
        tick();
        acc_prev = 1'b1;
        for (int c = 0; c < 500; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req_valid || acc_prev) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_write = ($urandom_range(0, 1) != 0);
                a = 4'($urandom_range(0, 15));
                if (a == 4'd7) a = 4'd8;
                req_addr  = a;
                req_wdata = $urandom;
            end
            acc_prev = req_valid && req_ready;
            tick();
        end
        drain("t5");
        chk("t5_scoreboard", n_ret, n_acc);
        single("t5_rd7", 1'b0, 4'd7, 32'h0, 1'b0, 1'b0, d7);

        // 6: reset with three requests outstanding
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 32'h12345678;
        tick();
        req_write = 1'b0;
        tick();
        req_addr = 4'd0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t6_pre_vld", rsp_valid, 1);
        chk("t6_pre_outst", q.size(), 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_vld", rsp_valid, 0);
        chk("t6_rst_ready", req_ready, 1);
        chk("t6_rst_rdata", rsp_rdata, 0);
        chk("t6_rst_err", rsp_err, 0);
        tick();
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        nvld = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid) nvld++;
        end
        chk("t6_no_stale", nvld, 0);
        single("t6_rd3", 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, 32'h0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
